// File: rtl/glitc_intercom_rx_align.sv
// Receive aligner/decoder for the GLITC intercom link: per-lane bit-offset lock on a
// training nibble, then reassembly and decode of the 20-bit intercom word.
module glitc_intercom_rx_align #(
    parameter bit          INVERT       = 1'b0,
    parameter int          NBITS        = 5,
    parameter logic [3:0]  TRAIN_NIBBLE = 4'hE,
    parameter int          LOCK_CYCLES  = 16
) (
    input  logic               sysclk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               relock_i,
    input  logic [4*NBITS-1:0] iq_i,
    output logic [1:0]         command_o,
    output logic [5:0]         corr_o,
    output logic [11:0]        power_o,
    output logic               valid_o,
    output logic               locked_o,
    output logic [NBITS-1:0]   lane_locked_o
);

    localparam int         W        = 4 * NBITS;
    localparam logic [7:0] LOCK_CNT = 8'(LOCK_CYCLES);
    localparam logic [W-1:0] TRAIN_WORD = {NBITS{TRAIN_NIBBLE}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_reg;
    logic             locked_reg;
    logic [W-1:0]     r0_reg;
    logic [W-1:0]     r1_reg;
    logic [W-1:0]     aligned_reg;
    logic [W-1:0]     aligned_next;
    logic [NBITS-1:0] lane_locked;
    logic             lane_clear;
    logic             searching;
    logic             decode_ok;
    logic [1:0]       command_reg;
    logic [5:0]       corr_reg;
    logic [11:0]      power_reg;
    logic             valid_reg;

    // Locks and counts drop whenever the FSM leaves or restarts the search.
    assign lane_clear = (state_reg == IDLE) || !en_i || relock_i;
    assign searching  = (state_reg == SEARCH);

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            r0_reg <= '0;
            r1_reg <= '0;
        end else begin
            r0_reg <= INVERT ? ~iq_i : iq_i;
            r1_reg <= r0_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBITS; gi++) begin : g_lane
            logic [7:0] window;
            logic [3:0] lane_sel;
            logic [1:0] match_off;
            logic       match_found;
            logic [1:0] cand_reg;
            logic [1:0] cand_next;
            logic [1:0] offset_reg;
            logic [7:0] count_reg;
            logic [7:0] count_next;
            logic       lock_reg;

            assign window = {r1_reg[4*gi +: 4], r0_reg[4*gi +: 4]};

            // Descending scan so the lowest matching offset wins.
            always_comb begin
                match_found = 1'b0;
                match_off   = 2'd0;
                for (int k = 3; k >= 0; k--) begin
                    if (window[7-k -: 4] == TRAIN_NIBBLE) begin
                        match_found = 1'b1;
                        match_off   = 2'(k);
                    end
                end
                count_next = 8'd0;
                cand_next  = cand_reg;
                if (match_found) begin
                    if (match_off == cand_reg) begin
                        count_next = count_reg + 8'd1;
                    end else begin
                        count_next = 8'd1;
                        cand_next  = match_off;
                    end
                end
            end

            always_comb begin
                case (offset_reg)
                    2'd0:    lane_sel = window[7:4];
                    2'd1:    lane_sel = window[6:3];
                    2'd2:    lane_sel = window[5:2];
                    default: lane_sel = window[4:1];
                endcase
            end

            always_ff @(posedge sysclk_i or posedge rst_i) begin
                if (rst_i) begin
                    cand_reg   <= 2'd0;
                    count_reg  <= 8'd0;
                    offset_reg <= 2'd0;
                    lock_reg   <= 1'b0;
                end else if (lane_clear) begin
                    cand_reg  <= 2'd0;
                    count_reg <= 8'd0;
                    lock_reg  <= 1'b0;
                end else if (searching && !lock_reg) begin
                    cand_reg  <= cand_next;
                    count_reg <= count_next;
                    if (count_next == LOCK_CNT) begin
                        lock_reg   <= 1'b1;
                        offset_reg <= cand_next;
                    end
                end
            end

            assign aligned_next[4*gi +: 4] = lane_sel;
            assign lane_locked[gi]         = lock_reg;
        end
    endgenerate

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            locked_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    locked_reg <= 1'b0;
                    if (en_i) state_reg <= SEARCH;
                end
                SEARCH: begin
                    if (!en_i) begin
                        state_reg  <= IDLE;
                        locked_reg <= 1'b0;
                    end else if (relock_i) begin
                        state_reg  <= SEARCH;
                        locked_reg <= 1'b0;
                    end else if (&lane_locked) begin
                        state_reg  <= LOCKED;
                        locked_reg <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!en_i) begin
                        state_reg  <= IDLE;
                        locked_reg <= 1'b0;
                    end else if (relock_i) begin
                        state_reg  <= SEARCH;
                        locked_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    locked_reg <= 1'b0;
                end
            endcase
        end
    end

    // Idle (all ones) and training words never reach the field registers.
    assign decode_ok = (state_reg == LOCKED) && en_i && !relock_i &&
                       (aligned_reg != '1) && (aligned_reg != TRAIN_WORD);

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            aligned_reg <= '0;
            valid_reg   <= 1'b0;
            command_reg <= 2'd0;
            corr_reg    <= 6'd0;
            power_reg   <= 12'd0;
        end else begin
            aligned_reg <= aligned_next;
            valid_reg   <= decode_ok;
            if (decode_ok) begin
                power_reg   <= aligned_reg[11:0];
                corr_reg    <= aligned_reg[17:12];
                command_reg <= aligned_reg[19:18];
            end
        end
    end

    assign command_o     = command_reg;
    assign corr_o        = corr_reg;
    assign power_o       = power_reg;
    assign valid_o       = valid_reg;
    assign locked_o      = locked_reg;
    assign lane_locked_o = lane_locked;

endmodule

// File: tb/tb_glitc_intercom_rx_align.sv
// Bench for glitc_intercom_rx_align: a normal and an INVERT=1 instance run the same
// logical stream; a scoreboard tracks every data word through the 3-cycle pipeline.
module tb_glitc_intercom_rx_align;

    localparam logic [19:0] TRAIN_W = 20'hEEEEE;
    localparam logic [19:0] IDLE_W  = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        relock;
    logic [19:0] iq;
    logic [19:0] iq_n;

    logic [1:0]  cmd0, cmd1;
    logic [5:0]  corr0, corr1;
    logic [11:0] pow0, pow1;
    logic        v0, v1, lk0, lk1;
    logic [4:0]  ll0, ll1;

    typedef struct {
        int          due;
        logic [19:0] word;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          dly[5] = '{0, 0, 0, 0, 0};
    logic [19:0] prev_word = 20'h0;
    logic [19:0] last_exp = 20'h0;

    assign iq_n = ~iq;

    always #5 clk = ~clk;

    glitc_intercom_rx_align #(.INVERT(1'b0), .NBITS(5), .TRAIN_NIBBLE(4'hE), .LOCK_CYCLES(16)) dut0 (
        .sysclk_i(clk), .rst_i(rst), .en_i(en), .relock_i(relock), .iq_i(iq),
        .command_o(cmd0), .corr_o(corr0), .power_o(pow0), .valid_o(v0),
        .locked_o(lk0), .lane_locked_o(ll0)
    );

    glitc_intercom_rx_align #(.INVERT(1'b1), .NBITS(5), .TRAIN_NIBBLE(4'hE), .LOCK_CYCLES(16)) dut1 (
        .sysclk_i(clk), .rst_i(rst), .en_i(en), .relock_i(relock), .iq_i(iq_n),
        .command_o(cmd1), .corr_o(corr1), .power_o(pow1), .valid_o(v1),
        .locked_o(lk1), .lane_locked_o(ll1)
    );

    // Physical lane nibbles: each lane's logical bit stream delayed by dly[i] bits.
    function automatic logic [19:0] phys(input logic [19:0] cur, input logic [19:0] prev);
        logic [19:0] res;
        logic [7:0]  t;
        res = '0;
        for (int i = 0; i < 5; i++) begin
            t = {prev[4*i +: 4], cur[4*i +: 4]} >> dly[i];
            res[4*i +: 4] = t[3:0];
        end
        return res;
    endfunction

    // One clock: drive a logical word, optionally expect it 3 edges later, then
    // pop/compare whatever the scoreboard says is due this cycle.
    task automatic tick(input logic [19:0] word, input bit data);
        exp_t e;
        bit   exp_v;
        iq = phys(word, prev_word);
        prev_word = word;
        if (data) begin
            e.due  = cyc + 4;
            e.word = word;
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #2;
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        n_checks++;
        if (v0 !== exp_v || v1 !== exp_v) begin
            n_fail++;
            $display("FAIL valid cyc=%0d: got %b/%b expected %b", cyc, v0, v1, exp_v);
        end
        if (exp_v) begin
            e = sb.pop_front();
            n_checks++;
            if ({cmd0, corr0, pow0} !== e.word || {cmd1, corr1, pow1} !== e.word) begin
                n_fail++;
                $display("FAIL fields cyc=%0d: got %h/%h expected %h", cyc,
                         {cmd0, corr0, pow0}, {cmd1, corr1, pow1}, e.word);
            end
            last_exp = e.word;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; relock = 1'b0; iq = 20'h0;
        #1;
        n_checks++;
        if ({cmd0, corr0, pow0, v0, lk0, ll0} !== 26'd0 || {cmd1, corr1, pow1, v1, lk1, ll1} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %h/%h expected 0",
                     {cmd0, corr0, pow0, v0, lk0, ll0}, {cmd1, corr1, pow1, v1, lk1, ll1});
        end
        tick(TRAIN_W, 1'b0);
        tick(TRAIN_W, 1'b0);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) tick(TRAIN_W, 1'b0);
        n_checks++;
        if (lk0 !== 1'b0 || ll0 !== 5'h00 || lk1 !== 1'b0 || ll1 !== 5'h00) begin
            n_fail++;
            $display("FAIL idle_no_lock: locked=%b/%b lanes=%h/%h expected 0", lk0, lk1, ll0, ll1);
        end
    endtask

    task automatic test_train_lock();
        en = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            tick(TRAIN_W, 1'b0);
            if (j == 16) begin
                n_checks++;
                if (ll0 !== 5'h00 || ll1 !== 5'h00) begin
                    n_fail++;
                    $display("FAIL lock_early: lanes=%h/%h expected 00", ll0, ll1);
                end
            end
            if (j == 17) begin
                n_checks++;
                if (ll0 !== 5'h1F || ll1 !== 5'h1F || lk0 !== 1'b0 || lk1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_time: lanes=%h/%h locked=%b/%b expected 1f,0", ll0, ll1, lk0, lk1);
                end
            end
            if (j == 18) begin
                n_checks++;
                if (lk0 !== 1'b1 || lk1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL locked_rise: locked=%b/%b expected 1", lk0, lk1);
                end
            end
        end
    endtask

    task automatic test_back_to_back(input logic [19:0] final_word);
        logic [19:0] w;
        for (int j = 0; j < 6; j++) begin
            w = 20'($urandom);
            if (w == IDLE_W || w == TRAIN_W) w = 20'h12345;
            tick(w, 1'b1);
        end
        tick(final_word, 1'b1);
        for (int j = 0; j < 4; j++) tick(TRAIN_W, 1'b0);
    endtask

    task automatic test_relock();
        relock = 1'b1;
        tick(TRAIN_W, 1'b0);
        relock = 1'b0;
        n_checks++;
        if (lk0 !== 1'b0 || ll0 !== 5'h00 || lk1 !== 1'b0 || ll1 !== 5'h00) begin
            n_fail++;
            $display("FAIL relock_drop: locked=%b/%b lanes=%h/%h expected 0", lk0, lk1, ll0, ll1);
        end
        for (int j = 1; j <= 17; j++) begin
            tick(TRAIN_W, 1'b0);
            if (j == 16) begin
                n_checks++;
                if (ll0 !== 5'h1F || ll1 !== 5'h1F || lk0 !== 1'b0 || lk1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL relock_lanes: lanes=%h/%h locked=%b/%b expected 1f,0", ll0, ll1, lk0, lk1);
                end
            end
            if (j == 17) begin
                n_checks++;
                if (lk0 !== 1'b1 || lk1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL relock_locked: locked=%b/%b expected 1", lk0, lk1);
                end
            end
        end
    endtask

    task automatic test_offset();
        dly[2] = 1;
        relock = 1'b1;
        tick(TRAIN_W, 1'b0);
        relock = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            tick(TRAIN_W, 1'b0);
            if (j == 16) begin
                n_checks++;
                if (ll0 !== 5'h1B || ll1 !== 5'h1B) begin
                    n_fail++;
                    $display("FAIL offset_lane2_late: lanes=%h/%h expected 1b", ll0, ll1);
                end
            end
            if (j == 17) begin
                n_checks++;
                if (ll0 !== 5'h1F || ll1 !== 5'h1F) begin
                    n_fail++;
                    $display("FAIL offset_lane2_lock: lanes=%h/%h expected 1f", ll0, ll1);
                end
            end
            if (j == 18) begin
                n_checks++;
                if (lk0 !== 1'b1 || lk1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL offset_locked: locked=%b/%b expected 1", lk0, lk1);
                end
            end
        end
        tick({2'b10, 6'h15, 12'hABC}, 1'b1);
        for (int j = 0; j < 5; j++) tick(TRAIN_W, 1'b0);
    endtask

    task automatic test_filter();
        tick(IDLE_W, 1'b0);
        tick(TRAIN_W, 1'b0);
        for (int j = 0; j < 4; j++) tick(TRAIN_W, 1'b0);
        n_checks++;
        if ({cmd0, corr0, pow0} !== last_exp || {cmd1, corr1, pow1} !== last_exp) begin
            n_fail++;
            $display("FAIL filter_hold: got %h/%h expected %h",
                     {cmd0, corr0, pow0}, {cmd1, corr1, pow1}, last_exp);
        end
        tick(20'h00000, 1'b1);
        for (int j = 0; j < 4; j++) tick(TRAIN_W, 1'b0);
    endtask

    task automatic test_broken_count();
        logic [19:0] w;
        relock = 1'b1;
        tick(TRAIN_W, 1'b0);
        relock = 1'b0;
        for (int j = 1; j <= 27; j++) begin
            w = TRAIN_W;
            if (j == 8) w[3:0] = 4'h0;
            tick(w, 1'b0);
            if (j == 16 || j == 25) begin
                n_checks++;
                if (ll0 !== 5'h1E || ll1 !== 5'h1E) begin
                    n_fail++;
                    $display("FAIL broken_restart j=%0d: lanes=%h/%h expected 1e", j, ll0, ll1);
                end
            end
            if (j == 26) begin
                n_checks++;
                if (ll0 !== 5'h1F || ll1 !== 5'h1F || lk0 !== 1'b0 || lk1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL broken_lock: lanes=%h/%h locked=%b/%b expected 1f,0", ll0, ll1, lk0, lk1);
                end
            end
            if (j == 27) begin
                n_checks++;
                if (lk0 !== 1'b1 || lk1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL broken_locked: locked=%b/%b expected 1", lk0, lk1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int  budget;
        relock = 1'b1;
        tick(TRAIN_W, 1'b0);
        relock = 1'b0;
        for (int j = 1; j <= 16; j++) tick(TRAIN_W, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cmd0, corr0, pow0, v0, lk0, ll0} !== 26'd0 || {cmd1, corr1, pow1, v1, lk1, ll1} !== 26'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%h expected 0",
                     {cmd0, corr0, pow0, v0, lk0, ll0}, {cmd1, corr1, pow1, v1, lk1, ll1});
        end
        tick(TRAIN_W, 1'b0);
        tick(TRAIN_W, 1'b0);
        rst = 1'b0;
        budget = 0;
        while (!(lk0 === 1'b1 && lk1 === 1'b1) && budget < 60) begin
            tick(TRAIN_W, 1'b0);
            budget++;
        end
        n_checks++;
        if (lk0 !== 1'b1 || lk1 !== 1'b1 || ll0 !== 5'h1F || ll1 !== 5'h1F) begin
            n_fail++;
            $display("FAIL relock_after_reset: locked=%b/%b lanes=%h/%h expected 1,1f", lk0, lk1, ll0, ll1);
        end
        tick({2'b01, 6'h2A, 12'h5C3}, 1'b1);
        for (int j = 0; j < 4; j++) tick(TRAIN_W, 1'b0);
    endtask

    initial begin
        test_reset();
        test_train_lock();
        test_back_to_back(20'h3C5A7);
        test_relock();
        test_offset();
        test_filter();
        test_back_to_back(20'h6D2B1);
        test_broken_count();
        test_reset_mid();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d words pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glitc_intercom_rx_align.md
# glitc_intercom_rx_align

Receive-side word aligner and decoder for the GLITC-to-GLITC intercom link. It takes the deserialized 4-bit-per-lane words of the NBITS intercom lanes, one word per sysclk cycle, after the lane ISERDES. It finds the per-lane bit offset by locking onto a training nibble, then reassembles the 20-bit intercom word. The word is decoded into command, correlation and power fields, and idle and training words are flagged so they do not produce valid data.

## Interface
- INVERT, 0: 1 = complement all incoming bits before alignment; matches the transmitter's lane polarity.
- NBITS, 5: number of lanes. The field map requires 5.
- TRAIN_NIBBLE, 4'hE: per-lane training nibble. It must have no rotational symmetry.
- LOCK_CYCLES, 16: consecutive matching cycles at the same offset needed to lock a lane (range 1..255).

- sysclk_i  in  1: the one clock; all logic on its rising edge.
- rst_i  in  1: asynchronous, active-high reset.
- en_i  in  1: enable; low forces IDLE.
- relock_i  in  1: one-cycle pulse; drops all locks and restarts the search.
- iq_i  in  4*NBITS: deserialized word. Lane i occupies [4i+3:4i]; bit 4i+3 is earliest in time.
- command_o  out  2: decoded command field.
- corr_o  out  6: decoded correlation field.
- power_o  out  12: decoded power field.
- valid_o  out  1: fields hold a new data word this cycle.
- locked_o  out  1: all lanes locked, state is LOCKED.
- lane_locked_o  out  NBITS: per-lane lock flags.

## Operation
- **Input pipeline:** r0 <= iq_i (inverted if INVERT=1), r1 <= r0, every cycle in every state.
- **Per-lane window:** w = {r1 nibble, r0 nibble}, 8 bits. Offset k (0..3) selects w[7-k -: 4].
- **Per-lane search** (SEARCH state, lane not locked):
  - m = lowest k whose selection equals TRAIN_NIBBLE.
  - No match: count <= 0.
  - m equals the stored candidate: count <= count+1.
  - m differs: candidate <= m, count <= 1.
  - When count reaches LOCK_CYCLES, the lane sets lane_locked and latches offset <= candidate.
  - A locked lane holds its offset while the other lanes continue searching.
- **Aligned word:** A[4i+3:4i] = lane i selection at its latched offset.
  - power = A[11:0], corr = A[17:12], command = A[19:18].
- **FSM states:**
  - IDLE: all lane locks and counts cleared. Goes to SEARCH when en_i=1.
  - SEARCH: goes to LOCKED the cycle after all lane_locked bits are 1.
  - LOCKED: decodes every cycle.
  - From SEARCH or LOCKED: en_i=0 goes to IDLE. relock_i=1 goes to SEARCH with all locks and counts cleared.
  - Priority: en_i=0 > relock_i > lock completion.
- **valid_o** is 1 in LOCKED only when A is neither the idle word (all ones, the transmitter's reset output) nor the training word (TRAIN_NIBBLE on every lane).
- Field outputs update only when valid_o is asserted and hold their value otherwise.

## Timing
- **Reset values:** all outputs 0, state IDLE, r0/r1/offsets/counts 0.
- **Latency:** at offset 0, a word on iq_i sampled at edge N appears on the field outputs and valid_o after edge N+3.
  - Offset k>0: the output word starts k bits into the edge-N word.
  - Pipeline: r0 at edge N, r1 at edge N+1, aligned register at N+2, output register at N+3.
- **Lock time:** a lane locks LOCK_CYCLES cycles after its first match reaches the window.
- **locked_o:** rises one cycle after the last lane locks. lane_locked_o is registered.
- **valid_o:** it and the field registers cannot assert before the first aligned word in LOCKED.
- **On leaving LOCKED:** valid_o falls on the next edge. locked_o and lane_locked_o clear on the same edge as the state change.
- **Reset mid-operation:** reset asserted in any state returns everything to reset values immediately (asynchronous). Search resumes from scratch after release with en_i=1.

## Test plan
- Reset, en_i=1, all lanes feeding 4'hE, LOCK_CYCLES=16 -> lane_locked_o=5'h1F after 16 matching cycles. locked_o=1 one cycle later. All offsets 0. valid_o stays 0 during training.
- Lane 2 fed 4'b0111 repeatedly, other lanes 4'hE -> lane 2 offset=1, all lanes lock. Then transmit power=12'hABC, corr=6'h15, command=2'b10 -> power_o=12'hABC, corr_o=6'h15, command_o=2'b10, valid_o=1 for one cycle, 3 cycles after the word.
- After lock, feed the all-ones word, then the training word -> valid_o=0 and fields unchanged. Then data word 20'h00000 -> valid_o=1 with all fields 0.
- Match count broken at cycle 10 by one non-matching nibble -> that lane's count restarts. Lock completes 16 cycles after matching resumes.
- relock_i pulsed in LOCKED in the same cycle as en_i=1 -> next edge locked_o=0, lane_locked_o=0, valid_o=0. Re-lock after LOCK_CYCLES+1 cycles.
- INVERT=1 with inverted training and data stream -> identical decoded fields. rst_i asserted mid-SEARCH -> all outputs 0 without waiting for a clock edge.
